// File: rtl/fuzzy_degree_collector_if.sv
// fuzzy_degree_collector_if: sample-in / result-out handshake bundle for the degree collector
interface fuzzy_degree_collector_if #(
  parameter int LongBit_limit = 10,
  parameter int Deg_width = 4,
  parameter int Cnt_width = 8
);
  logic InValid;
  logic InReady;
  logic [2:0] LoaclFlag;
  logic [LongBit_limit-1:0] LongBitData;
  logic IsHit;
  logic ErrorReturn;
  logic OutValid;
  logic OutReady;
  logic [Deg_width-1:0] Degree;
  logic [1:0] Region;
  logic OutHit;
  logic OutError;
  logic [Cnt_width-1:0] ErrCount;
  modport master (
    output InValid, LoaclFlag, LongBitData, IsHit, ErrorReturn, OutReady,
    input InReady, OutValid, Degree, Region, OutHit, OutError, ErrCount
  );
  modport slave (
    input InValid, LoaclFlag, LongBitData, IsHit, ErrorReturn, OutReady,
    output InReady, OutValid, Degree, Region, OutHit, OutError, ErrCount
  );
endinterface

// File: rtl/fuzzy_degree_collector.sv
// fuzzy_degree_collector: serially counts ones in a thermometer membership word and reports degree/region
module fuzzy_degree_collector #(
  parameter int LongBit_limit = 10,
  parameter int Deg_width = $clog2(LongBit_limit + 1),
  parameter int Cnt_width = 8
) (
  input logic Clk,
  input logic RstN,
  fuzzy_degree_collector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, stateNext;
  logic [LongBit_limit-1:0] shiftReg;
  logic [Deg_width-1:0] bitIdx;
  logic accept, inError, lastBit;
  assign accept = bus.InValid && state == IDLE;
  assign inError = bus.ErrorReturn | (bus.LoaclFlag == 3'b000);
  assign lastBit = bitIdx == Deg_width'(LongBit_limit - 1);
  assign bus.InReady = state == IDLE;
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: stateNext = bus.InValid ? (inError ? DONE : SCAN) : IDLE;
      SCAN: stateNext = lastBit ? DONE : SCAN;
      DONE: stateNext = bus.OutReady ? IDLE : DONE;
      default: stateNext = IDLE;
    endcase
  end
  // erroneous samples skip the scan and report a zero degree immediately
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) begin
      shiftReg <= '0;
      bitIdx <= '0;
      bus.Degree <= '0;
      bus.Region <= '0;
      bus.OutHit <= 1'b0;
      bus.OutError <= 1'b0;
      bus.OutValid <= 1'b0;
      bus.ErrCount <= '0;
    end else if (accept) begin
      shiftReg <= bus.LongBitData;
      bitIdx <= '0;
      bus.Degree <= '0;
      bus.Region <= bus.LoaclFlag[0] ? 2'd3 : bus.LoaclFlag[1] ? 2'd2 : bus.LoaclFlag[2] ? 2'd1 : 2'd0;
      bus.OutHit <= bus.IsHit;
      bus.OutError <= inError;
      bus.OutValid <= inError;
      if (inError && !(&bus.ErrCount)) bus.ErrCount <= bus.ErrCount + Cnt_width'(1);
    end else if (state == SCAN) begin
      bus.Degree <= bus.Degree + Deg_width'(shiftReg[0]);
      shiftReg <= shiftReg >> 1;
      bitIdx <= bitIdx + Deg_width'(1);
      bus.OutValid <= lastBit;
    end else if (state == DONE && bus.OutReady) begin
      bus.OutValid <= 1'b0;
    end
endmodule
